cmplx_mult_driver: RTL and testbench

Initiator-side companion to the complex multiplier core. It buffers operand sets from an upstream source and drives them into the core over the op_val/op_ready handshake. It collects each result over the res_val/res_ready handshake and presents it downstream. A completion counter and a handshake watchdog flag a core that stops responding.

---
 rtl/cmplx_mult_driver.sv | 162 ++++++++++++++++
 tb/tb_cmplx_mult_driver.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmplx_mult_driver.sv
// Initiator-side driver for the complex multiplier core: buffers operand sets,
// issues them over op_val/op_ready, collects results and presents them downstream.
//
// state      | meaning
// IDLE       | nothing in flight, waiting for the FIFO to hold an operand set
// ISSUE      | op_data presented to the core, waiting for op_ready
// WAIT_RES   | operands accepted, waiting for the core result
// HOLD_OUT   | result registered, waiting for downstream out_ready
// ERROR      | watchdog expired; sticky until rst or sw_rst
module cmplx_mult_driver #(
  parameter int DATA_W  = 8,
  parameter int RES_W   = 17,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sw_rst,
  input  logic                  in_val,
  output logic                  in_ready,
  input  logic [4*DATA_W-1:0]   in_data,
  output logic                  op_val,
  input  logic                  op_ready,
  output logic [4*DATA_W-1:0]   op_data,
  input  logic                  res_val,
  output logic                  res_ready,
  input  logic [RES_W-1:0]      res_re,
  input  logic [RES_W-1:0]      res_im,
  output logic                  out_val,
  input  logic                  out_ready,
  output logic [RES_W-1:0]      out_re,
  output logic [RES_W-1:0]      out_im,
  output logic [15:0]           done_cnt,
  output logic                  busy,
  output logic                  err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ISSUE    = 3'd1;
  localparam logic [2:0] S_WAIT_RES = 3'd2;
  localparam logic [2:0] S_HOLD_OUT = 3'd3;
  localparam logic [2:0] S_ERROR    = 3'd4;

  logic [2:0]          state, state_nxt;
  logic [4*DATA_W-1:0] fifo_mem [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         count;
  logic                full, empty, push, pop;
  logic [TW-1:0]       timer;
  logic                timer_load;

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = !full && (state != S_ERROR);
  assign push      = in_val && in_ready;

  assign op_val    = (state == S_ISSUE);
  assign res_ready = (state == S_WAIT_RES);
  assign out_val   = (state == S_HOLD_OUT);
  assign err       = (state == S_ERROR);
  assign busy      = (state != S_IDLE) || !empty;

  // Watchdog is a down-counter loaded on entry; terminal count 0 without a handshake trips ERROR.
  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    timer_load = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          timer_load = 1'b1;
          state_nxt  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (op_ready) begin
          timer_load = 1'b1;
          state_nxt  = S_WAIT_RES;
        end else if (timer == '0) begin
          state_nxt = S_ERROR;
        end
      end
      S_WAIT_RES: begin
        if (res_val)
          state_nxt = S_HOLD_OUT;
        else if (timer == '0)
          state_nxt = S_ERROR;
      end
      S_HOLD_OUT: begin
        if (out_ready) begin
          if (!empty) begin
            pop        = 1'b1;
            timer_load = 1'b1;
            state_nxt  = S_ISSUE;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      S_ERROR: state_nxt = S_ERROR;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      timer    <= '0;
      op_data  <= '0;
      out_re   <= '0;
      out_im   <= '0;
      done_cnt <= '0;
    end else if (sw_rst) begin
      state    <= S_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      timer    <= '0;
      op_data  <= '0;
      out_re   <= '0;
      out_im   <= '0;
      done_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        op_data <= fifo_mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (timer_load)
        timer <= TW'(TIMEOUT - 1);
      else if (timer != '0)
        timer <= timer - 1'b1;
      if ((state == S_WAIT_RES) && res_val) begin
        out_re <= res_re;
        out_im <= res_im;
      end
      if ((state == S_HOLD_OUT) && out_ready)
        done_cnt <= done_cnt + 16'd1;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_cmplx_mult_driver.sv
// Directed bench for cmplx_mult_driver: each task drives one scenario and
// checks against hand-computed values.
module tb_cmplx_mult_driver;

  logic        clk = 1'b0;
  logic        rst, sw_rst;
  logic        in_val, in_ready;
  logic [31:0] in_data;
  logic        op_val, op_ready;
  logic [31:0] op_data;
  logic        res_val, res_ready;
  logic [16:0] res_re, res_im;
  logic        out_val, out_ready;
  logic [16:0] out_re, out_im;
  logic [15:0] done_cnt;
  logic        busy, err;

  int vectors     = 0;
  int miscompares = 0;

  cmplx_mult_driver #(.DATA_W(8), .RES_W(17), .DEPTH(4), .TIMEOUT(32)) dut (
    .clk(clk), .rst(rst), .sw_rst(sw_rst),
    .in_val(in_val), .in_ready(in_ready), .in_data(in_data),
    .op_val(op_val), .op_ready(op_ready), .op_data(op_data),
    .res_val(res_val), .res_ready(res_ready), .res_re(res_re), .res_im(res_im),
    .out_val(out_val), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .done_cnt(done_cnt), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] set_word(input logic [7:0] k);
    return {8'h10 + k, 8'h20 + k, 8'h30 + k, 8'h40 + k};
  endfunction

  task automatic wait_op(input int limit, output bit ok);
    int n;
    n  = 0;
    ok = op_val;
    while (!ok && n < limit) begin
      tick();
      n++;
      ok = op_val;
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1; sw_rst = 1'b0;
    in_val = 1'b0; in_data = '0; op_ready = 1'b0;
    res_val = 1'b0; res_re = '0; res_im = '0; out_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset_dut();
    rst = 1'b1;
    #2;
    vectors++;
    if ({op_val, res_ready, out_val, err, busy} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got op/res/out/err/busy=%05b want 00000",
               {op_val, res_ready, out_val, err, busy});
    end
    vectors++;
    if (op_data !== 32'h0 || out_re !== 17'h0 || out_im !== 17'h0 || done_cnt !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_data: got op_data=%h out_re=%h out_im=%h done=%0d want all 0",
               op_data, out_re, out_im, done_cnt);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_single();
    reset_dut();
    in_data = 32'h03040502; in_val = 1'b1;
    tick();
    in_val = 1'b0;
    vectors++;
    if (op_val !== 1'b0) begin
      miscompares++;
      $display("FAIL single_op_val_c1: got %b want 0", op_val);
    end
    tick();
    vectors++;
    if (op_val !== 1'b1 || op_data !== 32'h03040502) begin
      miscompares++;
      $display("FAIL single_issue_c2: got op_val=%b op_data=%h want 1 03040502", op_val, op_data);
    end
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    vectors++;
    if (res_ready !== 1'b1 || op_val !== 1'b0) begin
      miscompares++;
      $display("FAIL single_wait_res: got res_ready=%b op_val=%b want 1 0", res_ready, op_val);
    end
    repeat (6) tick();
    res_re = 17'd7; res_im = 17'd26; res_val = 1'b1;
    tick();
    res_val = 1'b0;
    vectors++;
    if (out_val !== 1'b1 || out_re !== 17'd7 || out_im !== 17'd26) begin
      miscompares++;
      $display("FAIL single_result: got out_val=%b re=%0d im=%0d want 1 7 26", out_val, out_re, out_im);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    vectors++;
    if (done_cnt !== 16'd1 || busy !== 1'b0 || out_val !== 1'b0 || out_re !== 17'd7) begin
      miscompares++;
      $display("FAIL single_done: got done=%0d busy=%b out_val=%b re=%0d want 1 0 0 7",
               done_cnt, busy, out_val, out_re);
    end
  endtask

  task automatic test_fifo_full();
    int  acc, first_full;
    bit  ok;
    reset_dut();
    acc = 0; first_full = -1;
    for (int i = 0; i < 8; i++) begin
      in_data = set_word(8'(acc));
      in_val  = 1'b1;
      if (!in_ready && first_full < 0) first_full = i;
      if (in_ready) acc++;
      tick();
    end
    in_val = 1'b0;
    vectors++;
    if (acc != 5 || first_full != 5) begin
      miscompares++;
      $display("FAIL fifo_full_accept: got accepted=%0d first_full=%0d want 5 5", acc, first_full);
    end
    vectors++;
    if (in_ready !== 1'b0 || op_val !== 1'b1 || op_data !== set_word(8'd0)) begin
      miscompares++;
      $display("FAIL fifo_full_hold: got in_ready=%b op_val=%b op_data=%h want 0 1 %h",
               in_ready, op_val, op_data, set_word(8'd0));
    end
    for (int j = 0; j < 5; j++) begin
      wait_op(10, ok);
      vectors++;
      if (!ok || op_data !== set_word(8'(j))) begin
        miscompares++;
        $display("FAIL fifo_order_%0d: got op_val=%b op_data=%h want 1 %h", j, op_val, op_data, set_word(8'(j)));
      end
      op_ready = 1'b1;
      tick();
      op_ready = 1'b0;
      res_re = 17'(100 + j); res_im = 17'(200 + j); res_val = 1'b1;
      tick();
      res_val = 1'b0;
      vectors++;
      if (out_val !== 1'b1 || out_re !== 17'(100 + j) || out_im !== 17'(200 + j)) begin
        miscompares++;
        $display("FAIL fifo_result_%0d: got out_val=%b re=%0d im=%0d want 1 %0d %0d",
                 j, out_val, out_re, out_im, 100 + j, 200 + j);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    vectors++;
    if (done_cnt !== 16'd5 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL fifo_drain: got done=%0d busy=%b want 5 0", done_cnt, busy);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    reset_dut();
    in_val = 1'b1; in_data = set_word(8'h50);
    tick();
    in_data = set_word(8'h60);
    tick();
    in_val = 1'b0;
    wait_op(10, ok);
    vectors++;
    if (!ok || op_data !== set_word(8'h50)) begin
      miscompares++;
      $display("FAIL bp_first_issue: got op_val=%b op_data=%h want 1 %h", op_val, op_data, set_word(8'h50));
    end
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    res_re = 17'h1ABCD; res_im = 17'h0F0F0; res_val = 1'b1;
    tick();
    res_val = 1'b0;
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (out_val !== 1'b1 || out_re !== 17'h1ABCD || out_im !== 17'h0F0F0 || op_val !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold_%0d: got out_val=%b re=%h im=%h op_val=%b want 1 1abcd 0f0f0 0",
                 i, out_val, out_re, out_im, op_val);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    vectors++;
    if (op_val !== 1'b1 || op_data !== set_word(8'h60) || done_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL bp_release: got op_val=%b op_data=%h done=%0d want 1 %h 1",
               op_val, op_data, done_cnt, set_word(8'h60));
    end
    tick();
    vectors++;
    if (done_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL bp_done_once: got done=%0d want 1", done_cnt);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    reset_dut();
    in_val = 1'b1; in_data = set_word(8'h01);
    tick();
    in_val = 1'b0;
    wait_op(10, ok);
    op_ready = 1'b1; tick(); op_ready = 1'b0;
    res_val = 1'b1; tick(); res_val = 1'b0;
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    in_val = 1'b1; in_data = set_word(8'h02);
    tick();
    in_data = set_word(8'h03);
    tick();
    in_val = 1'b0;
    wait_op(10, ok);
    vectors++;
    if (!ok || done_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL to_setup: got op_val=%b done=%0d want 1 1", op_val, done_cnt);
    end
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    repeat (31) tick();
    vectors++;
    if (err !== 1'b0 || res_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL to_early: got err=%b res_ready=%b after 31 cycles want 0 1", err, res_ready);
    end
    tick();
    vectors++;
    if (err !== 1'b1 || res_ready !== 1'b0 || in_ready !== 1'b0 || op_val !== 1'b0) begin
      miscompares++;
      $display("FAIL to_trip: got err=%b res_ready=%b in_ready=%b op_val=%b want 1 0 0 0",
               err, res_ready, in_ready, op_val);
    end
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    vectors++;
    if (err !== 1'b0 || in_ready !== 1'b1 || done_cnt !== 16'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL to_sw_rst: got err=%b in_ready=%b done=%0d busy=%b want 0 1 0 0",
               err, in_ready, done_cnt, busy);
    end
    repeat (3) tick();
    vectors++;
    if (op_val !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL to_flushed: got op_val=%b busy=%b want 0 0", op_val, busy);
    end
  endtask

  task automatic test_negative();
    bit ok;
    reset_dut();
    in_val = 1'b1; in_data = 32'h00FF00FF;
    tick();
    in_val = 1'b0;
    wait_op(10, ok);
    vectors++;
    if (!ok || op_data !== 32'h00FF00FF) begin
      miscompares++;
      $display("FAIL neg_issue: got op_val=%b op_data=%h want 1 00ff00ff", op_val, op_data);
    end
    op_ready = 1'b1; tick(); op_ready = 1'b0;
    res_re = 17'h101FF; res_im = 17'h0; res_val = 1'b1;
    tick();
    res_val = 1'b0;
    vectors++;
    if (out_val !== 1'b1 || out_re !== 17'h101FF || out_im !== 17'h0) begin
      miscompares++;
      $display("FAIL neg_result: got out_val=%b re=%h im=%h want 1 101ff 0", out_val, out_re, out_im);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    bit ok;
    reset_dut();
    in_val = 1'b1; in_data = set_word(8'h07);
    tick();
    in_val = 1'b0;
    wait_op(10, ok);
    op_ready = 1'b1; tick(); op_ready = 1'b0;
    res_re = 17'h00123; res_im = 17'h00456; res_val = 1'b1; tick(); res_val = 1'b0;
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    in_val = 1'b1; in_data = set_word(8'h08);
    tick();
    in_val = 1'b0;
    wait_op(10, ok);
    op_ready = 1'b1; tick(); op_ready = 1'b0;
    vectors++;
    if (res_ready !== 1'b1 || done_cnt !== 16'd1 || out_re !== 17'h00123) begin
      miscompares++;
      $display("FAIL ar_setup: got res_ready=%b done=%0d re=%h want 1 1 00123", res_ready, done_cnt, out_re);
    end
    #3;
    rst = 1'b1;
    #1;
    vectors++;
    if ({op_val, res_ready, out_val, err, busy} !== 5'b0 || done_cnt !== 16'd0 ||
        op_data !== 32'h0 || out_re !== 17'h0 || out_im !== 17'h0) begin
      miscompares++;
      $display("FAIL ar_immediate: got flags=%05b done=%0d op_data=%h re=%h im=%h want 00000 0 0 0 0",
               {op_val, res_ready, out_val, err, busy}, done_cnt, op_data, out_re, out_im);
    end
    #2;
    rst = 1'b0;
    res_val = 1'b1;
    repeat (5) tick();
    res_val = 1'b0;
    vectors++;
    if (out_val !== 1'b0 || op_val !== 1'b0 || done_cnt !== 16'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL ar_no_resume: got out_val=%b op_val=%b done=%0d busy=%b want 0 0 0 0",
               out_val, op_val, done_cnt, busy);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_single();
    test_fifo_full();
    test_backpressure();
    test_timeout();
    test_negative();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
